// File: rtl/nes_pkg.sv
// nes_pkg: shared NES bus constants and the OAM DMA state encoding.
package nes_pkg;
  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } oam_dma_state_t;
endpackage

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine, copies a 256-byte page to OAMDATA on a write to OAMDMA.
// Ports: clk/rst (async active-low); cpu_addr/cpu_dout/cpu_rw observe the CPU core bus;
// mem_data is the byte read one cycle earlier; cpu_halt stalls the core; dma_active
// claims the bus and dma_addr/dma_rw/dma_dout drive it.
module oam_dma
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw,
  input  logic [7:0]  mem_data,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_dout
);
  oam_dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d, idx_q, idx_d;
  logic       parity_q;
  logic       trig;
  assign trig = state_q == ST_IDLE && !cpu_rw && cpu_addr == OAMDMA_ADDR;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = trig ? ST_HALT : ST_IDLE;
      // parity_q=1 now means the next cycle is a get cycle, so READ can start directly
      ST_HALT:  state_d = cpu_rw ? (parity_q ? ST_READ : ST_ALIGN) : ST_HALT;
      ST_ALIGN: state_d = ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = idx_q == 8'hFF ? ST_IDLE : ST_READ;
      default:  state_d = ST_IDLE;
    endcase
    page_d = trig ? cpu_dout : page_q;
    idx_d  = trig ? 8'h00 : state_q == ST_WRITE ? idx_q + 8'h01 : idx_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      parity_q <= ~parity_q;
    end
  end
  assign cpu_halt   = state_q != ST_IDLE;
  assign dma_active = state_q == ST_ALIGN || state_q == ST_READ || state_q == ST_WRITE;
  assign dma_rw     = state_q != ST_WRITE;
  assign dma_addr   = state_q == ST_WRITE ? OAMDATA_ADDR :
                      state_q == ST_READ  ? {page_q, idx_q} :
                      state_q == ST_ALIGN ? {page_q, 8'h00} : 16'h0000;
  // the byte fetched in READ arrives on mem_data during WRITE and is forwarded as-is
  assign dma_dout   = state_q == ST_WRITE ? mem_data : 8'h00;
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 clk  input  1  system clock, all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 cpu_addr  input  16  CPU core address bus.
REQ-004 cpu_dout  input  8  CPU core write data (data_from_cpu).
REQ-005 cpu_rw  input  1  CPU core bus direction; 1 = read, 0 = write.
REQ-006 mem_data  input  8  data returned by cpu_mmap; corresponds to the address presented in the previous cycle.
REQ-007 cpu_halt  output  1  high = CPU core stalled; top level maps it onto the core READY input.
REQ-008 dma_active  output  1  high = this block owns the bus; top-level mux selects dma_addr/dma_rw/dma_dout into cpu_mmap.
REQ-009 dma_addr  output  16  DMA bus address.
REQ-010 dma_rw  output  1  DMA bus direction; 1 = read, 0 = write.
REQ-011 dma_dout  output  8  DMA write data.

Function
REQ-012 Trigger: CPU write cycle (cpu_rw=0) with cpu_addr=16'h4014 in state IDLE latches cpu_dout as page and enters HALT on that edge.
REQ-013 A trigger write in any state other than IDLE is ignored; page is not re-latched.
REQ-014 Parity: 1-bit free-running toggle, 0 after reset, inverts every clk. Parity 0 = get cycle, parity 1 = put cycle.
REQ-015 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-016 HALT: cpu_halt=1, dma_active=0. Remain in HALT while cpu_rw=0, so the CPU finishes any write cycles.
REQ-017 HALT exit: on the first HALT cycle with cpu_rw=1 (the halt cycle), go to READ if the next cycle's parity is 0, otherwise go to ALIGN.
REQ-018 ALIGN: exactly one dummy cycle; dma_active=1, dma_rw=1, dma_addr={page,8'h00}; next state READ.
REQ-019 READ: dma_active=1, dma_rw=1, dma_addr={page,idx}; always on a parity-0 cycle; next state WRITE.
REQ-020 WRITE: dma_active=1, dma_rw=0, dma_addr=16'h2004, dma_dout=mem_data (combinational pass-through of the byte read in the preceding READ cycle).
REQ-021 WRITE exit: idx increments (8-bit); if idx was 8'hFF, go to IDLE, otherwise go to READ.
REQ-022 idx clears to 0 on trigger. Page 8'hFF reads 16'hFF00..16'hFFFF with no carry into the page.
REQ-023 cpu_halt=1 in HALT, ALIGN, READ, WRITE; 0 only in IDLE.
REQ-024 cpu_halt deasserts in the cycle after the final WRITE.
REQ-025 Outside its active states, dma_active=0, dma_rw=1, dma_addr=16'h0000, dma_dout=8'h00.
REQ-026 Cycle count with an immediate halt cycle: 513 halted cycles if the first READ follows HALT directly, 514 if ALIGN is inserted.
REQ-027 Exactly 256 READ and 256 WRITE cycles per transfer; exactly 256 writes to 16'h2004.
REQ-028 All outputs are decoded from registered state; no combinational path from cpu_* inputs to outputs, except dma_dout from mem_data in WRITE.

Reset
REQ-029 rst low forces, asynchronously: state=IDLE, page=0, idx=0, parity=0, cpu_halt=0, dma_active=0.
REQ-030 Reset mid-transfer aborts the transfer immediately; the CPU is released, with no completion of the current byte.
REQ-031 After rst rises, the first rising edge samples normally; a trigger on that edge is accepted.

Structure
REQ-032 Shared package nes_pkg holds OAMDMA_ADDR (16'h4014), OAMDATA_ADDR (16'h2004) and the oam_dma_state_t enum.
REQ-033 Single flat module; no sub-module (the parity toggle is too small to warrant one).

Verification
REQ-034 Page 8'h02, trigger on a parity-1 edge, next CPU cycle a read:
- ALIGN is skipped.
- 513 halted cycles.
- 256 writes to 16'h2004 carrying RAM[16'h0200..16'h02FF] in order.
REQ-035 Page 8'h03, parity arranged so the cycle after the halt cycle is odd:
- exactly one ALIGN cycle.
- 514 halted cycles.
- first READ occurs at parity 0.
REQ-036 Trigger followed by two CPU write cycles:
- HALT persists 3 cycles.
- dma_active rises only after the first cpu_rw=1 cycle.
REQ-037 Page 8'hFF:
- last READ address is 16'hFFFF.
- no access to 16'h0000.
- cpu_halt falls one cycle after the 256th write.
REQ-038 Second write of 8'h05 to 16'h4014 mid-transfer of page 8'h02:
- ignored.
- all reads stay in 16'h02xx.
REQ-039 rst low during WRITE of idx 8'h40:
- cpu_halt=0 and dma_active=0 asynchronously.
- after release, no 16'h2004 write until a new trigger.
